// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: direct-mapped, write-through, no-write-allocate cache
// controller with a 4-word line refilled one beat at a time from a backing
// memory. Hit/miss statistics are only built when CACHE_STATS_EN is defined;
// otherwise hit_count/miss_count are tied to zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; flush clears all valid bits here
// LOOKUP | tag compare on the latched address, decide hit/miss/write
// REFILL | fetching the 4 words of the line, one beat per mem_ack
// WRITE  | write-through of the latched word to backing memory
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_done,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int TAG_W = ADDR_WIDTH - SET_BITS - 4;
    localparam int SETS  = 2 ** SET_BITS;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, WRITE} state_t;

    state_t state, state_nxt;

    // Byte offset is never stored: accesses are word-aligned.
    logic [ADDR_WIDTH-1:2] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            beat;

    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS][4];

    logic [TAG_W-1:0]    tag_q;
    logic [SET_BITS-1:0] idx_q;
    logic [1:0]          off_q;
    logic                hit;
    logic                accept;
    logic                unused_addr_bits;

    assign tag_q  = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign idx_q  = addr_q[SET_BITS+3:4];
    assign off_q  = addr_q[3:2];
    assign hit    = valid[idx_q] && (tag_mem[idx_q] == tag_q);
    // cpu_done still high means the requester has not yet dropped cpu_req
    // for the transfer that just completed; flush takes precedence.
    assign accept = (state == IDLE) && cpu_req && !cpu_done && !flush;

    assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and memory-side outputs; memory outputs depend only on
    // registered state so they stay stable until the ack edge.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (we_q)     state_nxt = WRITE;
                else if (hit) state_nxt = IDLE;
                else          state_nxt = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag_q, idx_q, beat, 2'b00};
                if (mem_ack && (beat == 2'd3)) state_nxt = IDLE;
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q, 2'b00};
                mem_wdata = wdata_q;
                if (mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, beat counter, valid bits and CPU-side response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            beat      <= 2'd0;
            valid     <= '0;
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (accept) begin
                        addr_q  <= cpu_addr[ADDR_WIDTH-1:2];
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    beat <= 2'd0;
                    if (!we_q) begin
                        if (hit) begin
                            cpu_done  <= 1'b1;
                            cpu_rdata <= data_mem[idx_q][off_q];
                        end else begin
                            // Line is about to be overwritten beat by beat;
                            // keep it invalid until the last word lands.
                            valid[idx_q] <= 1'b0;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            valid[idx_q] <= 1'b1;
                            cpu_done     <= 1'b1;
                            // Requested word may be the one arriving right now.
                            cpu_rdata    <= (off_q == beat) ? mem_rdata
                                                            : data_mem[idx_q][off_q];
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) cpu_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Line storage (tags and data); contents are qualified by valid.
    always_ff @(posedge clk) begin
        if ((state == REFILL) && mem_ack) begin
            data_mem[idx_q][beat] <= mem_rdata;
            if (beat == 2'd3) tag_mem[idx_q] <= tag_q;
        end else if ((state == LOOKUP) && we_q && hit) begin
            data_mem[idx_q][off_q] <= wdata_q;
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating read hit/miss counters, counted at the LOOKUP decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state == LOOKUP) && !we_q) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed self-checking bench for cache_refill_ctrl. Expected statistics
// follow CACHE_STATS_EN (zero when the macro is not defined).
module tb_cache_refill_ctrl;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        flush = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    cache_refill_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .SET_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .flush(flush), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [0:16383];
    int          nreads;
    int          nwrites;
    logic [15:0] raddr [4];
    logic [15:0] waddr;
    logic [31:0] wdat;
    int          lat = 0;
    int          wait_cnt = 0;

    // Backing-memory responder, called once per falling edge.
    task automatic mem_step();
        if (mem_req) begin
            if (wait_cnt >= lat) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    waddr = mem_addr;
                    wdat  = mem_wdata;
                    mem_model[mem_addr[15:2]] = mem_wdata;
                    nwrites++;
                end else begin
                    if (nreads < 4) raddr[nreads] = mem_addr;
                    nreads++;
                    mem_rdata = mem_model[mem_addr[15:2]];
                end
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    endtask

    // One CPU access from a falling edge; returns read data and the number
    // of rising edges from acceptance to the edge that raised cpu_done.
    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output int edges);
        nreads = 0; nwrites = 0; wait_cnt = 0; rd = '0; edges = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (cpu_done) begin
                rd = cpu_rdata;
                cpu_req = 1'b0;
                mem_ack = 1'b0;
                @(negedge clk);
                checks++;
                if (cpu_done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse addr=%h: cpu_done=%b, required 0", a, cpu_done);
                end
                return;
            end
            mem_step();
        end
        checks++; errors++;
        $display("FAIL access_timeout addr=%h: no cpu_done, required within 60 cycles", a);
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (cpu_done !== 1'b0)  begin errors++; $display("FAIL rst_done: got %b required 0", cpu_done); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h required 0", cpu_rdata); end
        checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL rst_mem_req: got %b required 0", mem_req); end
        checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
        checks++; if (hit_count !== 16'h0) begin errors++; $display("FAIL rst_hits: got %h required 0", hit_count); end
        checks++; if (miss_count !== 16'h0) begin errors++; $display("FAIL rst_misses: got %h required 0", miss_count); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_read_miss();
        logic [31:0] rd; int edges;
        logic [15:0] exp_a [4];
        exp_a[0] = 16'h0120; exp_a[1] = 16'h0124; exp_a[2] = 16'h0128; exp_a[3] = 16'h012C;
        cpu_access(1'b0, 16'h0124, 32'h0, rd, edges);
        checks++; if (nreads !== 4) begin errors++; $display("FAIL miss_beats: got %0d required 4", nreads); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (raddr[i] !== exp_a[i]) begin
                errors++; $display("FAIL miss_addr[%0d]: got %h required %h", i, raddr[i], exp_a[i]);
            end
        end
        checks++; if (rd !== 32'hA1) begin errors++; $display("FAIL miss_rdata: got %h required 000000a1", rd); end
        checks++; if (edges !== 6) begin errors++; $display("FAIL miss_latency: got %0d required 6", edges); end
        checks++; if (miss_count !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL miss_count1: got %0d", miss_count); end
    endtask

    task automatic test_read_hit();
        logic [31:0] rd; int edges;
        cpu_access(1'b0, 16'h012C, 32'h0, rd, edges);
        checks++; if (nreads !== 0) begin errors++; $display("FAIL hit_memreq: got %0d beats required 0", nreads); end
        checks++; if (edges !== 2) begin errors++; $display("FAIL hit_latency: got %0d required 2", edges); end
        checks++; if (rd !== 32'hA3) begin errors++; $display("FAIL hit_rdata: got %h required 000000a3", rd); end
        checks++; if (hit_count !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL hit_count1: got %0d", hit_count); end
    endtask

    task automatic test_write();
        logic [31:0] rd; int edges;
        cpu_access(1'b1, 16'h0128, 32'hDEADBEEF, rd, edges);
        checks++; if (nwrites !== 1) begin errors++; $display("FAIL wr_count: got %0d required 1", nwrites); end
        checks++; if (waddr !== 16'h0128) begin errors++; $display("FAIL wr_addr: got %h required 0128", waddr); end
        checks++; if (wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data: got %h required deadbeef", wdat); end
        checks++; if (edges !== 3) begin errors++; $display("FAIL wr_latency: got %0d required 3", edges); end
        cpu_access(1'b0, 16'h0128, 32'h0, rd, edges);
        checks++; if (nreads !== 0) begin errors++; $display("FAIL wr_hit_memreq: got %0d required 0", nreads); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hit_rdata: got %h required deadbeef", rd); end
        checks++; if (hit_count !== (STATS ? 16'd2 : 16'd0)) begin errors++; $display("FAIL hit_count2: got %0d", hit_count); end
        // Write miss must not allocate: the line is still absent afterwards.
        cpu_access(1'b1, 16'h0330, 32'h11112222, rd, edges);
        checks++; if (waddr !== 16'h0330) begin errors++; $display("FAIL wmiss_addr: got %h required 0330", waddr); end
        cpu_access(1'b0, 16'h0334, 32'h0, rd, edges);
        checks++; if (nreads !== 4) begin errors++; $display("FAIL wmiss_noalloc: got %0d beats required 4", nreads); end
        checks++; if (rd !== 32'h000000CD) begin errors++; $display("FAIL wmiss_rdata: got %h required 000000cd", rd); end
    endtask

    task automatic test_evict();
        logic [31:0] rd; int edges;
        lat = 2;
        cpu_access(1'b0, 16'h0220, 32'h0, rd, edges);
        lat = 0;
        checks++; if (nreads !== 4) begin errors++; $display("FAIL evict_beats: got %0d required 4", nreads); end
        checks++; if (raddr[3] !== 16'h022C) begin errors++; $display("FAIL evict_addr3: got %h required 022c", raddr[3]); end
        checks++; if (rd !== 32'hB0) begin errors++; $display("FAIL evict_rdata: got %h required 000000b0", rd); end
        checks++; if (edges !== 14) begin errors++; $display("FAIL evict_latency: got %0d required 14", edges); end
        cpu_access(1'b0, 16'h0124, 32'h0, rd, edges);
        checks++; if (nreads !== 4) begin errors++; $display("FAIL evict_remiss: got %0d beats required 4", nreads); end
        checks++; if (rd !== 32'hA1) begin errors++; $display("FAIL evict_rdata2: got %h required 000000a1", rd); end
        cpu_access(1'b0, 16'h0128, 32'h0, rd, edges);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL evict_wt_data: got %h required deadbeef", rd); end
        checks++; if (miss_count !== (STATS ? 16'd4 : 16'd0)) begin errors++; $display("FAIL miss_count4: got %0d", miss_count); end
        checks++; if (hit_count !== (STATS ? 16'd3 : 16'd0)) begin errors++; $display("FAIL hit_count3: got %0d", hit_count); end
    endtask

    task automatic test_flush();
        logic [31:0] rd; int edges;
        flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0124;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_priority: busy=%b required 0", busy); end
        flush = 1'b0;
        cpu_access(1'b0, 16'h0124, 32'h0, rd, edges);
        checks++; if (nreads !== 4) begin errors++; $display("FAIL flush_miss: got %0d beats required 4", nreads); end
        checks++; if (edges !== 6) begin errors++; $display("FAIL flush_latency: got %0d required 6", edges); end
        checks++; if (miss_count !== (STATS ? 16'd5 : 16'd0)) begin errors++; $display("FAIL miss_count5: got %0d", miss_count); end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd; int edges; bit found;
        found = 1'b0; nreads = 0; wait_cnt = 0; lat = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0220;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_req && (mem_addr == 16'h0228)) begin
                found = 1'b1;
                break;
            end
            mem_step();
        end
        mem_ack = 1'b0;
        checks++;
        if (!found) begin errors++; $display("FAIL rst_refill_beat2: beat 2 address 0228 not seen"); end
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_refill_memreq: got %b required 0", mem_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_refill_busy: got %b required 0", busy); end
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cpu_access(1'b0, 16'h0220, 32'h0, rd, edges);
        checks++; if (nreads !== 4) begin errors++; $display("FAIL rst_refill_remiss: got %0d beats required 4", nreads); end
        checks++; if (rd !== 32'hB0) begin errors++; $display("FAIL rst_refill_rdata: got %h required 000000b0", rd); end
        checks++; if (miss_count !== (STATS ? 16'd1 : 16'd0)) begin errors++; $display("FAIL rst_refill_misses: got %0d", miss_count); end
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rst_refill_hits: got %0d required 0", hit_count); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem_model[i] = i;
        mem_model[14'h048] = 32'hA0; mem_model[14'h049] = 32'hA1;
        mem_model[14'h04A] = 32'hA2; mem_model[14'h04B] = 32'hA3;
        mem_model[14'h088] = 32'hB0; mem_model[14'h089] = 32'hB1;
        mem_model[14'h08A] = 32'hB2; mem_model[14'h08B] = 32'hB3;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_evict();
        test_flush();
        test_reset_mid_refill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte address width; field split is tag A[15:8], index A[7:4], word offset A[3:2], byte A[1:0].
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter SET_BITS, default 4, index width (16 sets); tag width = ADDR_WIDTH-SET_BITS-4.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cpu_req  in  1  requester holds high until cpu_done.
REQ-007 cpu_we  in  1  1=word write, 0=word read.
REQ-008 cpu_addr  in  ADDR_WIDTH  byte address; A[1:0] ignored (word-aligned only).
REQ-009 cpu_wdata  in  DATA_WIDTH  write data.
REQ-010 flush  in  1  invalidate all lines.
REQ-011 cpu_rdata  out  DATA_WIDTH  read data, registered, valid while cpu_done=1.
REQ-012 cpu_done  out  1  one-cycle completion pulse, registered.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 mem_req / mem_we  out  1 / 1  backing-memory request and write qualifier.
REQ-015 mem_addr  out  ADDR_WIDTH  word address to memory, A[1:0]=00.
REQ-016 mem_wdata  out  DATA_WIDTH;  mem_rdata  in  DATA_WIDTH;  mem_ack  in  1  beat complete.
REQ-017 hit_count / miss_count  out  16 / 16  statistics (see Configuration).

Function
REQ-018 SHALL hold internal storage of 2**SET_BITS lines, each {valid, tag, 4 words}, direct-mapped.
REQ-019 SHALL implement states IDLE, LOOKUP, REFILL, WRITE.
REQ-020 IDLE: accept a request when cpu_req=1 and cpu_done=0; latch addr/we/wdata; next state LOOKUP.
REQ-021 IDLE with flush=1: clear all valid bits in one cycle; flush wins over a simultaneous cpu_req, which is left pending.
REQ-022 LOOKUP read hit (valid and tag match): cpu_rdata = word[A[3:2]], cpu_done=1 on next cycle, go IDLE; total 2 edges from acceptance to done.
REQ-023 LOOKUP read miss: go REFILL, beat counter = 0.
REQ-024 REFILL: mem_req=1, mem_we=0, mem_addr={tag,index,beat,2'b00}; on edge with mem_ack=1 store mem_rdata into word[beat] and increment beat.
REQ-025 On the 4th ack: write valid=1 and the new tag, drive cpu_rdata from the refilled word[A[3:2]], pulse cpu_done, go IDLE.
REQ-026 LOOKUP write: go WRITE (write-through, no write-allocate); on hit, update cached word[A[3:2]] in the same edge.
REQ-027 WRITE: mem_req=1, mem_we=1, mem_addr={A[15:2],2'b00}, mem_wdata=latched data; on mem_ack pulse cpu_done, go IDLE.
REQ-028 mem_req, mem_we, mem_addr and mem_wdata SHALL be stable from assertion until the ack edge; mem_ack while mem_req=0 SHALL be ignored.
REQ-029 mem_req SHALL drop in the cycle after the final ack; no back-to-back beats within one cycle of ack are required (the next beat may reassert immediately).
REQ-030 A write miss SHALL leave the line unchanged; a refill SHALL overwrite whatever line occupies the index.
REQ-031 cpu_req and flush SHALL be ignored outside IDLE.

Reset
REQ-032 Reset SHALL force IDLE, clear all valid bits, clear the beat counter, and drive cpu_done=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, and counters=0.
REQ-033 Reset mid-REFILL SHALL discard the partial line (valid stays 0).

Configuration
REQ-034 With macro CACHE_STATS_EN defined: hit_count/miss_count SHALL increment by one on each read hit/read miss decided in LOOKUP, saturate at 16'hFFFF, and be unaffected by flush.
REQ-035 Without CACHE_STATS_EN: the ports SHALL remain present and be tied to 0, and no counter logic is built.

Verification
REQ-036 After reset, read 0x0124; memory returns 0xA0,0xA1,0xA2,0xA3 for 0x0120..0x012C -> mem_addr sequence 0x0120,0x0124,0x0128,0x012C, cpu_rdata=0xA1, miss_count=1.
REQ-037 Then read 0x012C -> no mem_req, cpu_done 2 edges after acceptance, cpu_rdata=0xA3, hit_count=1.
REQ-038 Write 0x0128=0xDEADBEEF, then read 0x0128 -> one mem write at 0x0128, then hit returning 0xDEADBEEF.
REQ-039 Read 0x0220 (same index 2, tag 0x02) -> refill evicts the line; a following read of 0x0124 misses again.
REQ-040 flush with cpu_req high in IDLE -> flush first, request accepted next cycle and misses; assert rst during beat 2 of a refill -> mem_req=0 immediately and a reread misses.
